// File: rtl/cnt_ns_fsm.sv
// Next-state logic and state register for the 8-bit up/down loadable counter.
// Optional build macro CNT_SAT_EN: saturate at FF/00 instead of wrapping, with no pulses.
module cnt_ns_fsm (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       load,
  input  logic       inc,
  input  logic       dec,
  input  logic [7:0] count_in,
  output logic [2:0] state,
  output logic       carry_out,
  output logic       borrow_out
);

  typedef enum logic [2:0] {
    IDLE_STATE = 3'b000,
    LOAD_STATE = 3'b001,
    INC_STATE  = 3'b010,
    INC2_STATE = 3'b011,
    DEC_STATE  = 3'b100,
    DEC2_STATE = 3'b101
  } state_e;

  state_e state_q, state_d;
  logic   carry_q, carry_d;
  logic   borrow_q, borrow_d;

  logic   inc_req, dec_req;
  logic   cnt_max, cnt_min;
  state_e inc_tgt, dec_tgt;

  assign inc_req = inc & ~dec;
  assign dec_req = dec & ~inc;
  assign cnt_max = (count_in == '1);
  assign cnt_min = (count_in == '0);

  // Alternate between the two phases so every counting cycle changes state.
  assign inc_tgt = (state_q == INC_STATE) ? INC2_STATE : INC_STATE;
  assign dec_tgt = (state_q == DEC_STATE) ? DEC2_STATE : DEC_STATE;

  always_comb begin
    state_d  = state_q;
    carry_d  = 1'b0;
    borrow_d = 1'b0;
    case (state_q)
      IDLE_STATE, LOAD_STATE, INC_STATE, INC2_STATE, DEC_STATE, DEC2_STATE: begin
        if (load) begin
          state_d = LOAD_STATE;
        end else if (inc_req) begin
`ifdef CNT_SAT_EN
          if (!cnt_max) state_d = inc_tgt;
`else
          state_d = inc_tgt;
          carry_d = cnt_max;
`endif
        end else if (dec_req) begin
`ifdef CNT_SAT_EN
          if (!cnt_min) state_d = dec_tgt;
`else
          state_d  = dec_tgt;
          borrow_d = cnt_min;
`endif
        end
      end
      // Unused encodings recover to idle regardless of commands.
      default: state_d = IDLE_STATE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE_STATE;
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      carry_q  <= carry_d;
      borrow_q <= borrow_d;
    end
  end

  assign state      = state_q;
  assign carry_out  = carry_q;
  assign borrow_out = borrow_q;

endmodule

// File: tb/tb_cnt_ns_fsm.sv
// Directed table-driven bench for cnt_ns_fsm, plus hand sequences for reset corner cases.
module tb_cnt_ns_fsm;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       load, inc, dec;
  logic [7:0] count_in;
  logic [2:0] state;
  logic       carry_out, borrow_out;

  int unsigned tests = 0;
  int unsigned fails = 0;

  cnt_ns_fsm dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (load),
    .inc        (inc),
    .dec        (dec),
    .count_in   (count_in),
    .state      (state),
    .carry_out  (carry_out),
    .borrow_out (borrow_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       ld, in, de;
    logic [7:0] cnt;
    logic [2:0] st;
    logic       cy, bw;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string name, input logic [2:0] st, input logic cy, input logic bw);
    chk({name, ".state"},  {5'd0, state},      {5'd0, st});
    chk({name, ".carry"},  {7'd0, carry_out},  {7'd0, cy});
    chk({name, ".borrow"}, {7'd0, borrow_out}, {7'd0, bw});
  endtask

  task automatic add(input logic ld, in, de, input logic [7:0] cnt,
                     input logic [2:0] st, input logic cy, bw);
    vec_t v;
    v.ld = ld; v.in = in; v.de = de; v.cnt = cnt; v.st = st; v.cy = cy; v.bw = bw;
    vecs.push_back(v);
  endtask

  task automatic apply(input logic ld, in, de, input logic [7:0] cnt);
    @(negedge clk);
    load = ld; inc = in; dec = de; count_in = cnt;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    //   ld in de  cnt     state   cy bw
    add(0, 0, 0, 8'h00, 3'b000, 0, 0);
    add(0, 0, 0, 8'h00, 3'b000, 0, 0);
    add(0, 0, 0, 8'h00, 3'b000, 0, 0);
    add(1, 0, 0, 8'h00, 3'b001, 0, 0);
    add(0, 1, 0, 8'h5A, 3'b010, 0, 0);
    add(0, 1, 0, 8'h5B, 3'b011, 0, 0);
    add(0, 1, 0, 8'h5C, 3'b010, 0, 0);
    add(1, 0, 0, 8'h5D, 3'b001, 0, 0);
`ifdef CNT_SAT_EN
    add(0, 1, 0, 8'hFF, 3'b001, 0, 0);
    add(0, 0, 0, 8'hFF, 3'b001, 0, 0);
    add(1, 0, 0, 8'hFF, 3'b001, 0, 0);
    add(0, 0, 1, 8'h00, 3'b001, 0, 0);
    add(0, 0, 1, 8'hFF, 3'b100, 0, 0);
`else
    add(0, 1, 0, 8'hFF, 3'b010, 1, 0);
    add(0, 0, 0, 8'h00, 3'b010, 0, 0);
    add(1, 0, 0, 8'h00, 3'b001, 0, 0);
    add(0, 0, 1, 8'h00, 3'b100, 0, 1);
    add(0, 0, 1, 8'hFF, 3'b101, 0, 0);
`endif
    add(0, 1, 0, 8'h00, 3'b010, 0, 0);
    add(0, 1, 0, 8'h01, 3'b011, 0, 0);
    add(0, 1, 1, 8'h02, 3'b011, 0, 0);
    add(0, 1, 1, 8'h02, 3'b011, 0, 0);
    add(1, 1, 0, 8'hFF, 3'b001, 0, 0);
    add(1, 0, 1, 8'h00, 3'b001, 0, 0);
    add(0, 0, 1, 8'h01, 3'b100, 0, 0);
    add(0, 1, 0, 8'hFE, 3'b010, 0, 0);
`ifdef CNT_SAT_EN
    add(0, 0, 1, 8'h00, 3'b010, 0, 0);
    add(0, 0, 0, 8'hFF, 3'b010, 0, 0);
`else
    add(0, 0, 1, 8'h00, 3'b100, 0, 1);
    add(0, 0, 0, 8'hFF, 3'b100, 0, 0);
`endif

    reset_n = 1'b0; load = 0; inc = 0; dec = 0; count_in = 8'h00;
    #1;
    chk_all("reset", 3'b000, 0, 0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i].ld, vecs[i].in, vecs[i].de, vecs[i].cnt);
      chk_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].cy, vecs[i].bw);
    end

    // Asynchronous reset in the middle of a cycle carrying a pulse.
    apply(1, 0, 0, 8'h10);
    apply(0, 0, 1, 8'h01);
    chk_all("rst_pre_dec", 3'b100, 0, 0);
    apply(0, 0, 1, 8'h00);
`ifdef CNT_SAT_EN
    chk_all("rst_pre_pulse", 3'b100, 0, 0);
`else
    chk_all("rst_pre_pulse", 3'b101, 0, 1);
`endif
    #2;
    reset_n = 1'b0;
    #1;
    chk_all("rst_async", 3'b000, 0, 0);
    @(posedge clk);
    #1;
    chk_all("rst_held", 3'b000, 0, 0);
    @(negedge clk);
    reset_n = 1'b1;
    apply(0, 1, 0, 8'h00);
    chk_all("rst_resume_inc", 3'b010, 0, 0);
    apply(0, 1, 0, 8'h01);
    chk_all("rst_resume_inc2", 3'b011, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
